// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point unpack pipeline.
// Formats, biases, exponent limits, class bit positions and result widths.
package fp_pkg;

  typedef enum logic [1:0] {
    FmtHalf   = 2'b00,
    FmtSingle = 2'b01,
    FmtDouble = 2'b10,
    FmtRsvd   = 2'b11
  } fmt_e;

  localparam int unsigned EXP_W  = 13;
  localparam int unsigned MANT_W = 53;
  localparam int unsigned FRAC_W = 52;
  localparam int unsigned CLS_W  = 6;

  localparam logic [EXP_W-1:0] BIAS_H = 13'd15;
  localparam logic [EXP_W-1:0] BIAS_S = 13'd127;
  localparam logic [EXP_W-1:0] BIAS_D = 13'd1023;

  localparam logic [10:0] EXP_MAX_H = 11'd31;
  localparam logic [10:0] EXP_MAX_S = 11'd255;
  localparam logic [10:0] EXP_MAX_D = 11'd2047;

  // One-hot class vector layout: {snan, qnan, inf, denormal, normal, zero}
  localparam int unsigned CLS_ZERO   = 0;
  localparam int unsigned CLS_NORMAL = 1;
  localparam int unsigned CLS_DENORM = 2;
  localparam int unsigned CLS_INF    = 3;
  localparam int unsigned CLS_QNAN   = 4;
  localparam int unsigned CLS_SNAN   = 5;

  function automatic logic [EXP_W-1:0] fmt_bias(input fmt_e f);
    case (f)
      FmtHalf:   return BIAS_H;
      FmtSingle: return BIAS_S;
      default:   return BIAS_D;
    endcase
  endfunction

endpackage

// File: rtl/fp_lzc52.sv
// Combinational leading-zero counter over a 52-bit fraction.
// An all-zero input reports 52.
module fp_lzc52 (
  input  logic [51:0] d_i,
  output logic [5:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last to overwrite the count.
  always_comb begin
    cnt_o = 6'd52;
    for (int i = 0; i < 52; i++) begin
      if (d_i[i]) cnt_o = 6'(51 - i);
    end
  end

endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage FP unpacker: S1 extracts fields, classifies and counts leading zeros;
// S2 normalizes denormals and produces the unbiased exponent.
module fp_unpack_pipe
  import fp_pkg::*;
#(
  parameter int unsigned LANES   = 1,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               fmt,
  input  logic [64*LANES-1:0]      fp_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         sign_out,
  output logic [EXP_W*LANES-1:0]   exp_out,
  output logic [MANT_W*LANES-1:0]  mant_out,
  output logic [CLS_W*LANES-1:0]   class_out,
  output logic                     fmt_err
);

  logic                s1_v_q, s2_v_q, skid_v_q;
  logic [1:0]          skid_fmt_q;
  logic [64*LANES-1:0] skid_data_q;
  fmt_e                s1_fmt_q;
  logic                s2_err_q;

  logic                s2_free, s1_free, in_xfer, s1_load, s2_load, skid_load;
  fmt_e                src_fmt;
  logic [64*LANES-1:0] src_data;

  assign s2_free   = !s2_v_q || out_ready;
  assign s1_free   = !s1_v_q || s2_free;
  // With the skid present, ready is a pure register so out_ready never reaches in_ready.
  assign in_ready  = !rst && ((OUT_REG != 0) ? !skid_v_q : s1_free);
  assign in_xfer   = in_valid && in_ready;
  assign skid_load = !skid_v_q && in_xfer && !s1_free;
  assign s1_load   = s1_free && (skid_v_q || in_xfer);
  assign s2_load   = s2_free && s1_v_q;
  assign src_fmt   = fmt_e'(skid_v_q ? skid_fmt_q : fmt);
  assign src_data  = skid_v_q ? skid_data_q : fp_in;
  assign out_valid = s2_v_q && !rst;
  assign fmt_err   = s2_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      if (s1_free) s1_v_q <= skid_v_q || in_xfer;
      if (s2_free) s2_v_q <= s1_v_q;
      if (skid_v_q && s1_free) skid_v_q <= 1'b0;
      else if (skid_load)      skid_v_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_fmt_q  <= fmt;
      skid_data_q <= fp_in;
    end
    if (s1_load) s1_fmt_q <= src_fmt;
    if (s2_load) s2_err_q <= (s1_fmt_q == FmtRsvd);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [63:0]        x;
    logic               sign_c;
    logic [10:0]        e_c, emax;
    logic [51:0]        f_c, f_norm;
    logic [5:0]         cls_c, lz_c;
    logic               s1_sign_q;
    logic [10:0]        s1_e_q;
    logic [51:0]        s1_f_q;
    logic [5:0]         s1_cls_q, s1_lz_q;
    logic [EXP_W-1:0]   bias, exp_c;
    logic [MANT_W-1:0]  mant_c;
    logic               s2_sign_q;
    logic [EXP_W-1:0]   s2_exp_q;
    logic [MANT_W-1:0]  s2_mant_q;
    logic [5:0]         s2_cls_q;

    assign x = src_data[64*i +: 64];

    always_comb begin
      sign_c = 1'b0;
      e_c    = '0;
      f_c    = '0;
      emax   = EXP_MAX_D;
      unique case (src_fmt)
        FmtHalf: begin
          sign_c = x[15];
          e_c    = {6'b0, x[14:10]};
          f_c    = {x[9:0], 42'b0};
          emax   = EXP_MAX_H;
        end
        FmtSingle: begin
          sign_c = x[31];
          e_c    = {3'b0, x[30:23]};
          f_c    = {x[22:0], 29'b0};
          emax   = EXP_MAX_S;
        end
        FmtDouble: begin
          sign_c = x[63];
          e_c    = x[62:52];
          f_c    = x[51:0];
          emax   = EXP_MAX_D;
        end
        FmtRsvd: ;
      endcase

      cls_c = '0;
      if (src_fmt == FmtRsvd)    cls_c[CLS_QNAN]   = 1'b1;
      else if (e_c == '0) begin
        if (f_c == '0)           cls_c[CLS_ZERO]   = 1'b1;
        else                     cls_c[CLS_DENORM] = 1'b1;
      end else if (e_c == emax) begin
        if (f_c == '0)           cls_c[CLS_INF]    = 1'b1;
        else if (f_c[51])        cls_c[CLS_QNAN]   = 1'b1;
        else                     cls_c[CLS_SNAN]   = 1'b1;
      end else                   cls_c[CLS_NORMAL] = 1'b1;
    end

    fp_lzc52 u_lzc (
      .d_i   (f_c),
      .cnt_o (lz_c)
    );

    always_ff @(posedge clk) begin
      if (s1_load) begin
        s1_sign_q <= sign_c;
        s1_e_q    <= e_c;
        s1_f_q    <= f_c;
        s1_cls_q  <= cls_c;
        s1_lz_q   <= lz_c;
      end
    end

    assign bias   = fmt_bias(s1_fmt_q);
    assign f_norm = s1_f_q << s1_lz_q;

    always_comb begin
      exp_c  = '0;
      mant_c = '0;
      if (s1_fmt_q != FmtRsvd) begin
        if (s1_cls_q[CLS_NORMAL]) begin
          exp_c  = {2'b0, s1_e_q} - bias;
          mant_c = {1'b1, s1_f_q};
        end else if (s1_cls_q[CLS_DENORM]) begin
          // Shifting by lz puts the leading one at bit 51; one more drops it into the hidden bit.
          exp_c  = '0 - bias - {7'b0, s1_lz_q};
          mant_c = {1'b1, f_norm[50:0], 1'b0};
        end else if (s1_cls_q[CLS_INF]) begin
          exp_c  = bias + 13'd1;
        end else if (s1_cls_q[CLS_QNAN] || s1_cls_q[CLS_SNAN]) begin
          exp_c  = bias + 13'd1;
          mant_c = {1'b0, s1_f_q};
        end
      end
    end

    always_ff @(posedge clk) begin
      if (s2_load) begin
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= exp_c;
        s2_mant_q <= mant_c;
        s2_cls_q  <= s1_cls_q;
      end
    end

    assign sign_out[i]                 = s2_sign_q;
    assign exp_out[EXP_W*i +: EXP_W]   = s2_exp_q;
    assign mant_out[MANT_W*i +: MANT_W] = s2_mant_q;
    assign class_out[CLS_W*i +: CLS_W] = s2_cls_q;
  end

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Bench for fp_unpack_pipe (4 lanes, skid present): directed vectors, reset cases and
// randomized traffic with a random-stalling consumer, scored against an arithmetic model.
module tb_fp_unpack_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   fmt = 2'b00;
  logic [255:0] fp_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [3:0]   sign_out;
  logic [51:0]  exp_out;
  logic [211:0] mant_out;
  logic [23:0]  class_out;
  logic         fmt_err;

  always #5 clk = ~clk;

  fp_unpack_pipe #(.LANES(4), .OUT_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .class_out (class_out),
    .fmt_err   (fmt_err)
  );

  localparam logic [5:0] C_ZERO   = 6'b000001;
  localparam logic [5:0] C_NORMAL = 6'b000010;
  localparam logic [5:0] C_DENORM = 6'b000100;
  localparam logic [5:0] C_INF    = 6'b001000;
  localparam logic [5:0] C_QNAN   = 6'b010000;
  localparam logic [5:0] C_SNAN   = 6'b100000;
  localparam logic [52:0] ONE52   = 53'h10000000000000;

  typedef struct packed {
    logic        sign;
    logic [12:0] exp;
    logic [52:0] mant;
    logic [5:0]  cls;
  } lane_t;

  typedef struct packed {
    logic         err;
    logic [3:0]   sign;
    logic [51:0]  exp;
    logic [211:0] mant;
    logic [23:0]  cls;
  } txn_t;

  txn_t q[$];
  txn_t cur;
  int   n_checks = 0;
  int   n_pass = 0;
  logic s_in_ready, s_out_valid;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  function automatic lane_t mk(input logic s, input int e, input logic [52:0] m,
                               input logic [5:0] c);
    lane_t l;
    l.sign = s;
    l.exp  = 13'(e);
    l.mant = m;
    l.cls  = c;
    return l;
  endfunction

  function automatic txn_t put_lane(input txn_t t, input int i, input lane_t l);
    txn_t r = t;
    r.sign[i]          = l.sign;
    r.exp[13*i +: 13]  = l.exp;
    r.mant[53*i +: 53] = l.mant;
    r.cls[6*i +: 6]    = l.cls;
    return r;
  endfunction

  // Reference: decode the value from the IEEE field rules with plain integer arithmetic.
  function automatic lane_t ref_lane(input logic [1:0] f, input logic [63:0] x);
    lane_t r;
    int fw, ew, bias, p;
    longint unsigned frac, e, emax;
    r = '0;
    if (f == 2'b11) begin
      r.cls = C_QNAN;
      return r;
    end
    fw   = (f == 2'b00) ? 10 : (f == 2'b01) ? 23 : 52;
    ew   = (f == 2'b00) ? 5 : (f == 2'b01) ? 8 : 11;
    bias = (1 << (ew - 1)) - 1;
    emax = (64'd1 << ew) - 1;
    frac = x & ((64'd1 << fw) - 1);
    e    = (x >> fw) & emax;
    r.sign = x[fw+ew];
    if (e == 0 && frac == 0) r.cls = C_ZERO;
    else if (e == 0) begin
      p = 0;
      for (int b = 0; b < fw; b++) if (frac[b]) p = b;
      r.cls  = C_DENORM;
      r.exp  = 13'(p + 1 - bias - fw);
      r.mant = 53'(frac << (52 - p));
    end else if (e == emax) begin
      r.exp = 13'(bias + 1);
      if (frac == 0) r.cls = C_INF;
      else begin
        r.cls  = frac[fw-1] ? C_QNAN : C_SNAN;
        r.mant = 53'(frac << (52 - fw));
      end
    end else begin
      r.cls  = C_NORMAL;
      r.exp  = 13'(int'(e) - bias);
      r.mant = 53'((64'd1 << 52) | (frac << (52 - fw)));
    end
    return r;
  endfunction

  function automatic txn_t ref_txn(input logic [1:0] f, input logic [255:0] d);
    txn_t t = '0;
    t.err = (f == 2'b11);
    for (int i = 0; i < 4; i++) t = put_lane(t, i, ref_lane(f, d[64*i +: 64]));
    return t;
  endfunction

  function automatic logic [63:0] gen_lane(input logic [1:0] f);
    logic [63:0] x, emask, fmask;
    int fw, ew;
    x  = {$urandom, $urandom};
    fw = (f == 2'b00) ? 10 : (f == 2'b01) ? 23 : 52;
    ew = (f == 2'b00) ? 5 : (f == 2'b01) ? 8 : 11;
    fmask = (64'd1 << fw) - 1;
    emask = ((64'd1 << ew) - 1) << fw;
    case ($urandom_range(0, 6))
      0: x = x & ~emask;
      1: x = x | emask;
      2: x = x & ~(emask | fmask);
      3: begin
        x = x & ~(emask | fmask);
        x[$urandom_range(0, fw - 1)] = 1'b1;
      end
      4: x = (x | emask) & ~fmask;
      default: ;
    endcase
    return x;
  endfunction

  // Inputs are already applied; sample 1 ns after the falling edge, score, then advance.
  task automatic step();
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) check_eq("spurious_out_valid", out_valid, 0);
      else begin
        check_eq("sign", sign_out, q[0].sign);
        check_eq("exp", exp_out, q[0].exp);
        check_eq("mant", mant_out, q[0].mant);
        check_eq("class", class_out, q[0].cls);
        check_eq("fmt_err", fmt_err, q[0].err);
        if (out_ready) void'(q.pop_front());
      end
    end
    if (in_valid && in_ready) q.push_back(cur);
    if (rst) q.delete();
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] f, input logic [255:0] d, input txn_t e);
    fmt = f;
    fp_in = d;
    cur = e;
    in_valid = 1'b1;
    s_in_ready = 1'b0;
    for (int k = 0; k < 50 && !s_in_ready; k++) step();
    if (!s_in_ready) check_eq("send_timeout", s_in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) step();
    check_eq("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txn_t e;
    logic [255:0] d;
    logic [1:0] f;
    int thr;

    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    check_eq("rst_in_ready", s_in_ready, 0);
    check_eq("rst_out_valid", s_out_valid, 0);
    rst = 1'b0;
    step();
    check_eq("post_rst_in_ready", s_in_ready, 1);
    check_eq("post_rst_out_valid", s_out_valid, 0);

    // single: zero, smallest denormal, +1.0, -1.0
    e = '0;
    e = put_lane(e, 0, mk(0, 0, 0, C_ZERO));
    e = put_lane(e, 1, mk(0, -149, ONE52, C_DENORM));
    e = put_lane(e, 2, mk(0, 0, ONE52, C_NORMAL));
    e = put_lane(e, 3, mk(1, 0, ONE52, C_NORMAL));
    send(2'b01, {64'hBF800000, 64'h3F800000, 64'h00000001, 64'h0}, e);
    step();
    check_eq("latency_c1", s_out_valid, 0);
    step();
    check_eq("latency_c2", s_out_valid, 1);

    // double: snan, qnan, zero, smallest denormal
    e = '0;
    e = put_lane(e, 0, mk(0, 1024, 53'h1, C_SNAN));
    e = put_lane(e, 1, mk(0, 1024, 53'h08000000000000, C_QNAN));
    e = put_lane(e, 2, mk(0, 0, 0, C_ZERO));
    e = put_lane(e, 3, mk(0, -1074, ONE52, C_DENORM));
    send(2'b10, {64'h1, 64'h0, 64'h7FF8000000000000, 64'h7FF0000000000001}, e);

    // reserved format
    e = '0;
    e.err = 1'b1;
    for (int i = 0; i < 4; i++) e = put_lane(e, i, mk(0, 0, 0, C_QNAN));
    send(2'b11, {4{64'hDEADBEEF3F800000}}, e);

    // half: qnan, -inf, 1.0, smallest denormal
    e = '0;
    e = put_lane(e, 0, mk(0, 16, 53'h08000000000000, C_QNAN));
    e = put_lane(e, 1, mk(1, 16, 0, C_INF));
    e = put_lane(e, 2, mk(0, 0, ONE52, C_NORMAL));
    e = put_lane(e, 3, mk(0, -24, ONE52, C_DENORM));
    send(2'b00, {64'h0001, 64'h3C00, 64'hFC00, 64'h7E00}, e);
    drain();

    // reset with two transactions in flight
    d = {gen_lane(2'b01), gen_lane(2'b01), gen_lane(2'b01), gen_lane(2'b01)};
    send(2'b01, d, ref_txn(2'b01, d));
    d = {gen_lane(2'b10), gen_lane(2'b10), gen_lane(2'b10), gen_lane(2'b10)};
    send(2'b10, d, ref_txn(2'b10, d));
    rst = 1'b1;
    step();
    check_eq("midrst_out_valid", s_out_valid, 0);
    check_eq("midrst_in_ready", s_in_ready, 0);
    rst = 1'b0;
    step();
    check_eq("after_midrst_out_valid", s_out_valid, 0);
    check_eq("after_midrst_in_ready", s_in_ready, 1);
    for (int k = 0; k < 4; k++) step();

    // randomized traffic, consumer stall rate varies by phase
    for (int n = 0; n < 900; n++) begin
      thr = (n < 300) ? 3 : (n < 600) ? 1 : 2;
      f = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'(($urandom_range(0, 2)));
      d = {gen_lane(f), gen_lane(f), gen_lane(f), gen_lane(f)};
      fmt = f;
      fp_in = d;
      cur = ref_txn(f, d);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) < thr);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
